// File: rtl/ysyx_22050368_wbck_pkg.sv
// Shared widths and source tags for the writeback stage.
// Defaults mirror the core-wide register file geometry.
package ysyx_22050368_wbck_pkg;

  localparam int WBCK_XLEN         = 64;
  localparam int WBCK_RFIDX_WIDTH  = 5;
  localparam int WBCK_RFREG_NUM    = 32;
  localparam int WBCK_STARVE_LIMIT = 2;

  typedef enum logic {
    WBCK_SRC_ALU = 1'b0,
    WBCK_SRC_LSU = 1'b1
  } wbck_src_e;

  function automatic int streak_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/ysyx_22050368_wbck_scoreboard.sv
// Busy bits for in-flight load destinations and decoder hazard lookup.
// x0 is never marked busy, so it can never raise a hazard.
module ysyx_22050368_wbck_scoreboard
  import ysyx_22050368_wbck_pkg::*;
#(
  parameter int RFIDX_WIDTH = WBCK_RFIDX_WIDTH,
  parameter int RFREG_NUM   = WBCK_RFREG_NUM
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_set_vld,
  input  logic [RFIDX_WIDTH-1:0] i_set_idx,
  input  logic                   i_clr_vld,
  input  logic [RFIDX_WIDTH-1:0] i_clr_idx,
  input  logic                   i_wb_wen,
  input  logic [RFIDX_WIDTH-1:0] i_wb_idx,
  input  logic [RFIDX_WIDTH-1:0] i_rs1_idx,
  input  logic [RFIDX_WIDTH-1:0] i_rs2_idx,
  input  logic [RFIDX_WIDTH-1:0] i_rd_idx,
  output logic                   o_hazard
);

  logic [RFREG_NUM-1:0] r_busy;
  logic [RFREG_NUM-1:0] w_set;
  logic [RFREG_NUM-1:0] w_clr;
  logic                 w_busy_hit;
  logic                 w_wb_hit;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_set_vld && (i_set_idx != '0))
      w_set[i_set_idx] = 1'b1;
    if (i_clr_vld)
      w_clr[i_clr_idx] = 1'b1;
  end

  // A reissue landing on the clearing edge keeps the register busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_busy <= '0;
    else
      r_busy <= (r_busy & ~w_clr) | w_set;
  end

  assign w_busy_hit = r_busy[i_rs1_idx]
                    | r_busy[i_rs2_idx]
                    | r_busy[i_rd_idx];

  // Result sitting in the output register is not yet in the file.
  assign w_wb_hit = i_wb_wen
                  & (i_wb_idx != '0)
                  & ((i_wb_idx == i_rs1_idx)
                  |  (i_wb_idx == i_rs2_idx));

  assign o_hazard = w_busy_hit | w_wb_hit;

endmodule

// File: rtl/ysyx_22050368_wbck.sv
// Writeback arbiter (LSU priority with ALU anti-starvation),
// registered register-file write port and load scoreboard.
module ysyx_22050368_wbck
  import ysyx_22050368_wbck_pkg::*;
#(
  parameter int XLEN         = WBCK_XLEN,
  parameter int RFIDX_WIDTH  = WBCK_RFIDX_WIDTH,
  parameter int RFREG_NUM    = WBCK_RFREG_NUM,
  parameter int STARVE_LIMIT = WBCK_STARVE_LIMIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_wbck_valid,
  output logic                   alu_wbck_ready,
  input  logic [RFIDX_WIDTH-1:0] alu_wbck_idx,
  input  logic [XLEN-1:0]        alu_wbck_dat,
  input  logic                   lsu_wbck_valid,
  output logic                   lsu_wbck_ready,
  input  logic [RFIDX_WIDTH-1:0] lsu_wbck_idx,
  input  logic [XLEN-1:0]        lsu_wbck_dat,
  input  logic                   lsu_issue_valid,
  input  logic [RFIDX_WIDTH-1:0] lsu_issue_idx,
  input  logic [RFIDX_WIDTH-1:0] dec_rs1_idx,
  input  logic [RFIDX_WIDTH-1:0] dec_rs2_idx,
  input  logic [RFIDX_WIDTH-1:0] dec_rd_idx,
  output logic                   dec_hazard,
  output logic                   wbck_dest_wen,
  output logic [RFIDX_WIDTH-1:0] wbck_dest_idx,
  output logic [XLEN-1:0]        wbck_dest_dat
);

  localparam int SW = streak_width(STARVE_LIMIT);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  logic [SW-1:0]          r_streak;
  logic                   r_wen;
  logic [RFIDX_WIDTH-1:0] r_idx;
  logic [XLEN-1:0]        r_dat;
  wbck_src_e              r_src;

  logic                   w_both;
  logic                   w_starved;
  logic                   w_alu_gnt;
  logic                   w_lsu_gnt;
  logic                   w_gnt;
  logic [RFIDX_WIDTH-1:0] w_sel_idx;
  logic [XLEN-1:0]        w_sel_dat;
  wbck_src_e              w_sel_src;

  assign w_both    = alu_wbck_valid & lsu_wbck_valid;
  assign w_starved = (r_streak == LIM);

  // Ready is the grant itself: valids plus streak, never data.
  assign w_lsu_gnt = ~rst & lsu_wbck_valid
                   & ~(alu_wbck_valid & w_starved);
  assign w_alu_gnt = ~rst & alu_wbck_valid
                   & (~lsu_wbck_valid | w_starved);
  assign w_gnt     = w_alu_gnt | w_lsu_gnt;

  assign alu_wbck_ready = w_alu_gnt;
  assign lsu_wbck_ready = w_lsu_gnt;

  always_comb begin
    w_sel_idx = alu_wbck_idx;
    w_sel_dat = alu_wbck_dat;
    w_sel_src = WBCK_SRC_ALU;
    if (w_lsu_gnt) begin
      w_sel_idx = lsu_wbck_idx;
      w_sel_dat = lsu_wbck_dat;
      w_sel_src = WBCK_SRC_LSU;
    end
  end

  // Counts LSU wins over a waiting ALU; any other cycle clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_streak <= '0;
    else if (w_both && !w_starved)
      r_streak <= r_streak + SW'(1);
    else
      r_streak <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen <= 1'b0;
      r_idx <= '0;
      r_dat <= '0;
      r_src <= WBCK_SRC_ALU;
    end else begin
      r_wen <= w_gnt & (w_sel_idx != '0);
      if (w_gnt) begin
        r_idx <= w_sel_idx;
        r_dat <= w_sel_dat;
        r_src <= w_sel_src;
      end
    end
  end

  assign wbck_dest_wen = r_wen;
  assign wbck_dest_idx = r_idx;
  assign wbck_dest_dat = r_dat;

  ysyx_22050368_wbck_scoreboard #(
    .RFIDX_WIDTH (RFIDX_WIDTH),
    .RFREG_NUM   (RFREG_NUM)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .i_set_vld (lsu_issue_valid),
    .i_set_idx (lsu_issue_idx),
    .i_clr_vld (r_wen & (r_src == WBCK_SRC_LSU)),
    .i_clr_idx (r_idx),
    .i_wb_wen  (r_wen),
    .i_wb_idx  (r_idx),
    .i_rs1_idx (dec_rs1_idx),
    .i_rs2_idx (dec_rs2_idx),
    .i_rd_idx  (dec_rd_idx),
    .o_hazard  (dec_hazard)
  );

endmodule
